// File: rtl/vec_replay_ctrl.sv
// Replay sequencer: vectors loaded over a config port are played one per cycle
// onto a DUT input bus, with pause/abort and a MISR over the DUT response.
module vec_replay_ctrl #(
    parameter int                VEC_W  = 46,
    parameter int                ADDR_W = 5,
    parameter int                RESP_W = 30,
    parameter logic [RESP_W-1:0] POLY   = 30'h20000003
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_cfg_we,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [VEC_W-1:0]  i_cfg_wdata,
    input  logic [ADDR_W:0]   i_cfg_len,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_abort,
    input  logic [RESP_W-1:0] i_resp_in,
    output logic [VEC_W-1:0]  o_vec_out,
    output logic              o_vec_valid,
    output logic              o_obs,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_pc,
    output logic [RESP_W-1:0] o_signature
);

    localparam int              DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W:0] PC_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_nxt;
    logic [VEC_W-1:0]  r_mem [DEPTH];
    logic [VEC_W-1:0]  r_vec_out;
    logic              r_vec_valid;
    logic              r_done;
    logic [ADDR_W:0]   r_pc;
    logic [ADDR_W:0]   r_len_q;
    logic [RESP_W-1:0] r_sig;

    logic              w_cfg_ok;
    logic              w_last;
    logic              w_apply;
    logic              w_misr_upd;
    logic [RESP_W-1:0] w_misr_nxt;
    logic [VEC_W-1:0]  w_rd;

    assign w_cfg_ok   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_last     = (r_pc == r_len_q - PC_ONE);
    // Leaving PAUSE applies the next vector on the same edge, so RUN and PAUSE share this path.
    assign w_apply    = ((r_state == S_RUN) || (r_state == S_PAUSE)) && !i_abort && !i_pause;
    assign w_misr_upd = r_vec_valid && !i_abort;
    assign w_misr_nxt = {r_sig[RESP_W-2:0], 1'b0} ^ (r_sig[RESP_W-1] ? POLY : '0) ^ i_resp_in;
    assign w_rd       = r_mem[r_pc[ADDR_W-1:0]];

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_nxt = (i_cfg_len != '0) ? S_RUN : S_DONE;
            S_RUN,
            S_PAUSE: begin
                if      (i_abort) w_nxt = S_IDLE;
                else if (i_pause) w_nxt = S_PAUSE;
                else if (w_last)  w_nxt = S_DRAIN;
                else              w_nxt = S_RUN;
            end
            S_DRAIN: w_nxt = i_abort ? S_IDLE : S_DONE;
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // RAM is not reset; writes are locked out while a replay is in flight.
    always_ff @(posedge i_clock) begin
        if (i_cfg_we && w_cfg_ok) r_mem[i_cfg_addr] <= i_cfg_wdata;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vec_out   <= '0;
            r_vec_valid <= 1'b0;
            r_done      <= 1'b0;
            r_pc        <= '0;
            r_len_q     <= '0;
            r_sig       <= '0;
        end else begin
            r_done      <= (r_state == S_DONE);
            r_vec_valid <= w_apply;
            if (w_apply) begin
                r_vec_out <= w_rd;
                r_pc      <= r_pc + PC_ONE;
            end
            if ((r_state == S_IDLE) && i_start) begin
                r_sig <= '0;
                if (i_cfg_len != '0) begin
                    r_len_q <= i_cfg_len;
                    r_pc    <= '0;
                end
            end else if (w_misr_upd) begin
                r_sig <= w_misr_nxt;
            end
        end
    end

    assign o_vec_out   = r_vec_out;
    assign o_vec_valid = r_vec_valid;
    assign o_obs       = r_vec_out[VEC_W-1];
    assign o_busy      = (r_state == S_RUN) || (r_state == S_PAUSE) || (r_state == S_DRAIN);
    assign o_done      = r_done;
    assign o_pc        = r_pc;
    assign o_signature = r_sig;

endmodule

// File: tb/tb_vec_replay_ctrl.sv
// Bench for vec_replay_ctrl: constant-response table, fixed pause/abort/reset
// sequences and randomized runs against a schedule-based reference model.
module tb_vec_replay_ctrl;
    localparam logic [29:0] POLY = 30'h20000003;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, pause, abort;
    logic [4:0]  cfg_addr;
    logic [45:0] cfg_wdata;
    logic [5:0]  cfg_len;
    logic [29:0] resp;
    logic [45:0] vec_out;
    logic        vec_valid, obs, busy, done;
    logic [5:0]  pc;
    logic [29:0] sig;

    int n_vec = 0;
    int n_err = 0;

    logic [45:0] bmem [32];
    logic        p_arr [128];
    logic [29:0] r_arr [128];

    typedef struct {
        int          len;
        logic [29:0] resp;
        logic [29:0] sig;
        int          edges;
    } tvec_t;
    tvec_t tv [6];

    always #5 clk = ~clk;

    vec_replay_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
        .i_cfg_wdata(cfg_wdata), .i_cfg_len(cfg_len), .i_start(start), .i_pause(pause),
        .i_abort(abort), .i_resp_in(resp), .o_vec_out(vec_out), .o_vec_valid(vec_valid),
        .o_obs(obs), .o_busy(busy), .o_done(done), .o_pc(pc), .o_signature(sig)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [29:0] misr(input logic [29:0] s, input logic [29:0] r);
        return {s[28:0], 1'b0} ^ (s[29] ? POLY : 30'h0) ^ r;
    endfunction

    task automatic wr(input int a, input logic [45:0] d);
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_wdata = d;
        bmem[a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Run with constant response; expectations come from the table entry.
    task automatic run_const(input tvec_t t);
        int edges, nv;
        resp = t.resp; cfg_len = 6'(t.len); start = 1'b1;
        tick();
        start = 1'b0; edges = 1; nv = 0;
        while (!done && edges < 100) begin
            if (vec_valid) nv++;
            tick();
            edges++;
        end
        chk("tbl_done_seen", 64'(done), 64'd1);
        chk("tbl_done_latency", 64'(edges), 64'(t.edges));
        chk("tbl_signature", 64'(sig), 64'(t.sig));
        chk("tbl_valid_count", 64'(nv), 64'(t.len));
        if (t.len > 0) begin
            chk("tbl_pc_at_done", 64'(pc), 64'(t.len));
            chk("tbl_last_vec_held", 64'(vec_out), 64'(bmem[t.len-1]));
        end
        tick();
        chk("tbl_done_one_cycle", 64'(done), 64'd0);
    endtask

    // Reference: vector k is applied on the k-th non-paused cycle after start;
    // done shows two edges after the last apply; the MISR folds the response
    // sampled on the edge following each applied vector.
    task automatic run_model(input int len, input bit noise);
        int ck [32];
        int k, c_last, a;
        logic [29:0] es;
        k = 0;
        for (int c = 0; c < 128; c++)
            if (!p_arr[c] && k < len) begin ck[k] = c; k++; end
        c_last = ck[len-1];
        es = 30'h0;
        for (int j = 0; j < len; j++) es = misr(es, r_arr[ck[j]+1]);
        cfg_len = 6'(len); start = 1'b1; pause = 1'b0;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        chk("mdl_busy_after_start", 64'(busy), 64'd1);
        chk("mdl_valid_after_start", 64'(vec_valid), 64'd0);
        chk("mdl_pc_cleared", 64'(pc), 64'd0);
        chk("mdl_sig_cleared", 64'(sig), 64'd0);
        for (int c = 0; c <= c_last + 2; c++) begin
            pause = p_arr[c]; resp = r_arr[c];
            if (noise && c <= c_last + 1) begin
                cfg_we = 1'($urandom_range(0, 1));
                cfg_addr = 5'($urandom);
                cfg_wdata = 46'({$urandom, $urandom});
            end else cfg_we = 1'b0;
            tick();
            a = 0;
            for (int j = 0; j < len; j++) if (ck[j] <= c) a++;
            chk("mdl_vec_valid", 64'(vec_valid), 64'(a > 0 && ck[a-1] == c));
            chk("mdl_pc", 64'(pc), 64'(a));
            chk("mdl_busy", 64'(busy), 64'(c <= c_last));
            chk("mdl_done", 64'(done), 64'(c == c_last + 2));
            if (a > 0) begin
                chk("mdl_vec_out", 64'(vec_out), 64'(bmem[a-1]));
                chk("mdl_obs", 64'(obs), 64'(bmem[a-1][45]));
            end
        end
        cfg_we = 1'b0; pause = 1'b0;
        chk("mdl_signature", 64'(sig), 64'(es));
    endtask

    initial begin
        int n, dn;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_len = '0;
        start = 1'b0; pause = 1'b0; abort = 1'b0; resp = '0;
        tick(); tick();
        chk("rst_vec_out", 64'(vec_out), 64'd0);
        chk("rst_vec_valid", 64'(vec_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_sig", 64'(sig), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) wr(i, 46'(i + 1));

        tv[0] = '{3, 30'h0,        30'h0, 6};
        tv[1] = '{2, 30'h1,        30'h3, 5};
        tv[2] = '{1, 30'h5,        30'h5, 4};
        tv[3] = '{3, 30'h1,        30'h7, 6};
        tv[4] = '{0, 30'h9,        30'h0, 2};
        tv[5] = '{2, 30'h20000000, 30'h3, 5};
        for (int i = 0; i < 6; i++) run_const(tv[i]);

        // Pause held three cycles after the second vector, config writes attempted while busy.
        for (int c = 0; c < 128; c++) begin p_arr[c] = 1'b0; r_arr[c] = 30'($urandom); end
        p_arr[2] = 1'b1; p_arr[3] = 1'b1; p_arr[4] = 1'b1;
        run_model(4, 1'b1);

        // Abort while the second vector of four is on the bus.
        resp = 30'h5; cfg_len = 6'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_pc", 64'(pc), 64'd2);
        chk("abort_valid", 64'(vec_valid), 64'd0);
        chk("abort_vec_held", 64'(vec_out), 64'(bmem[1]));
        chk("abort_sig_held", 64'(sig), 64'h5);
        dn = 0;
        repeat (6) begin tick(); if (done) dn++; end
        chk("abort_no_done", 64'(dn), 64'd0);
        cfg_len = 6'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_pc", 64'(pc), 64'd0);
        chk("restart_sig", 64'(sig), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("restart_done", 64'(done), 64'd1);
        chk("restart_sig_final", 64'(sig), 64'hf);
        chk("restart_pc_final", 64'(pc), 64'd2);

        // Randomized runs: random RAM, length, pause pattern and response.
        repeat (6) begin
            for (int i = 0; i < 32; i++) wr(i, 46'({$urandom, $urandom}));
            for (int c = 0; c < 128; c++) begin
                p_arr[c] = (c < 64) ? ($urandom_range(0, 3) == 0) : 1'b0;
                r_arr[c] = 30'($urandom);
            end
            run_model($urandom_range(1, 32), 1'b1);
        end

        // Full RAM with observe flag; mem[0] rewritten on the start edge.
        for (int i = 1; i < 32; i++) wr(i, 46'(i) | (46'd1 << 45));
        wr(0, 46'h123);
        for (int c = 0; c < 128; c++) begin p_arr[c] = 1'b0; r_arr[c] = 30'($urandom); end
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 46'd1 << 45; bmem[0] = 46'd1 << 45;
        run_model(32, 1'b0);

        // Reset in the middle of a run.
        cfg_len = 6'd32; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_vec_out", 64'(vec_out), 64'd0);
        chk("midrst_valid", 64'(vec_valid), 64'd0);
        chk("midrst_obs", 64'(obs), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_pc", 64'(pc), 64'd0);
        chk("midrst_sig", 64'(sig), 64'd0);
        tick();
        chk("midrst_stays_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
